// File: rtl/ycrcb422_to_444_pkg.sv
// Shared types and constants for the 4:2:2 to 4:4:4 chroma upsampler.
package ycrcb422_to_444_pkg;

    localparam int unsigned DW_DEFAULT = 10;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StFlush0,
        StFlush1
    } state_e;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_CB = 2'd0;
    localparam phase_t PH_Y0 = 2'd1;
    localparam phase_t PH_CR = 2'd2;
    localparam phase_t PH_Y1 = 2'd3;

endpackage

// File: rtl/ycrcb422_to_444_if.sv
// Word-stream input and pixel output bundle of the 4:2:2 to 4:4:4 upsampler.
interface ycrcb422_to_444_if
    import ycrcb422_to_444_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) ();

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_sol;
    logic          in_eol;
    logic          out_valid;
    logic [DW-1:0] y;
    logic [DW-1:0] cr;
    logic [DW-1:0] cb;
    logic          out_sol;
    logic          out_eol;

    // Upstream source / pixel sink side.
    modport master (
        output in_data, in_valid, in_sol, in_eol,
        input  in_ready, out_valid, y, cr, cb, out_sol, out_eol
    );

    // Upsampler side.
    modport slave (
        input  in_data, in_valid, in_sol, in_eol,
        output in_ready, out_valid, y, cr, cb, out_sol, out_eol
    );

endinterface

// File: rtl/chroma_avg.sv
// Rounded mean of two chroma samples, (a + b + 1) >> 1 evaluated at DW+1 bits.
module chroma_avg #(
    parameter int unsigned DW = 10
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] avg_o
);

    logic [DW:0] sum;

    assign sum   = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, 1'b1};
    assign avg_o = DW'(sum >> 1);

endmodule

// File: rtl/ycrcb422_to_444.sv
// Converts a Cb,Y,Cr,Y word stream into registered 4:4:4 pixels, interpolating
// chroma for odd pixels from the neighbouring pairs and replicating it at line end.
module ycrcb422_to_444
    import ycrcb422_to_444_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    ycrcb422_to_444_if.slave bus
);

    state_e        state_q, state_d;
    phase_t        phase_q, phase_d;
    // Held pair k and the partially received pair k+1.
    logic [DW-1:0] h_cb_q, h_cb_d, h_y0_q, h_y0_d, h_cr_q, h_cr_d, h_y1_q, h_y1_d;
    logic [DW-1:0] n_cb_q, n_cb_d, n_y0_q, n_y0_d, n_cr_q, n_cr_d;
    logic          sol_pend_q, sol_pend_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sol_q, out_sol_d;
    logic          out_eol_q, out_eol_d;
    logic [DW-1:0] y_q, y_d, cb_q, cb_d, cr_q, cr_d;

    logic          in_ready;
    logic          accept;
    logic          start;
    logic          emit;
    logic          px_eol;
    logic [DW-1:0] px_y, px_cb, px_cr;
    logic [DW-1:0] avg_cb, avg_cr;

    chroma_avg #(.DW(DW)) u_avg_cb (
        .a_i   (h_cb_q),
        .b_i   (n_cb_q),
        .avg_o (avg_cb)
    );

    chroma_avg #(.DW(DW)) u_avg_cr (
        .a_i   (h_cr_q),
        .b_i   (n_cr_q),
        .avg_o (avg_cr)
    );

    assign in_ready = rst_n && (state_q != StFlush0) && (state_q != StFlush1);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        h_cb_d     = h_cb_q;
        h_y0_d     = h_y0_q;
        h_cr_d     = h_cr_q;
        h_y1_d     = h_y1_q;
        n_cb_d     = n_cb_q;
        n_y0_d     = n_y0_q;
        n_cr_d     = n_cr_q;
        sol_pend_d = sol_pend_q;
        start      = 1'b0;
        emit       = 1'b0;
        px_eol     = 1'b0;
        px_y       = '0;
        px_cb      = '0;
        px_cr      = '0;

        case (state_q)
            StIdle: begin
                if (accept && bus.in_sol) start = 1'b1;
            end
            StFill: begin
                if (accept) begin
                    if (bus.in_sol) begin
                        start = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        case (phase_q)
                            PH_Y0: h_y0_d = bus.in_data;
                            PH_CR: h_cr_d = bus.in_data;
                            PH_Y1: begin
                                h_y1_d  = bus.in_data;
                                state_d = bus.in_eol ? StFlush0 : StRun;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    if (bus.in_sol) begin
                        start = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        case (phase_q)
                            PH_CB: n_cb_d = bus.in_data;
                            PH_Y0: n_y0_d = bus.in_data;
                            PH_CR: begin
                                n_cr_d = bus.in_data;
                                emit   = 1'b1;
                                px_y   = h_y0_q;
                                px_cb  = h_cb_q;
                                px_cr  = h_cr_q;
                            end
                            PH_Y1: begin
                                emit   = 1'b1;
                                px_y   = h_y1_q;
                                px_cb  = avg_cb;
                                px_cr  = avg_cr;
                                // The pair just completed becomes the held pair.
                                h_cb_d = n_cb_q;
                                h_y0_d = n_y0_q;
                                h_cr_d = n_cr_q;
                                h_y1_d = bus.in_data;
                                if (bus.in_eol) state_d = StFlush0;
                            end
                        endcase
                    end
                end
            end
            StFlush0: begin
                emit    = 1'b1;
                px_y    = h_y0_q;
                px_cb   = h_cb_q;
                px_cr   = h_cr_q;
                state_d = StFlush1;
            end
            StFlush1: begin
                emit    = 1'b1;
                px_y    = h_y1_q;
                px_cb   = h_cb_q;
                px_cr   = h_cr_q;
                px_eol  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A start-of-line word restarts decoding from any accepting state.
        if (start) begin
            state_d    = StFill;
            phase_d    = PH_Y0;
            h_cb_d     = bus.in_data;
            sol_pend_d = 1'b1;
        end

        y_d         = y_q;
        cb_d        = cb_q;
        cr_d        = cr_q;
        out_valid_d = 1'b0;
        out_sol_d   = 1'b0;
        out_eol_d   = 1'b0;
        if (emit) begin
            out_valid_d = 1'b1;
            y_d         = px_y;
            cb_d        = px_cb;
            cr_d        = px_cr;
            out_sol_d   = sol_pend_q;
            out_eol_d   = px_eol;
            sol_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            phase_q     <= PH_CB;
            h_cb_q      <= '0;
            h_y0_q      <= '0;
            h_cr_q      <= '0;
            h_y1_q      <= '0;
            n_cb_q      <= '0;
            n_y0_q      <= '0;
            n_cr_q      <= '0;
            sol_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            y_q         <= '0;
            cb_q        <= '0;
            cr_q        <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            h_cb_q      <= h_cb_d;
            h_y0_q      <= h_y0_d;
            h_cr_q      <= h_cr_d;
            h_y1_q      <= h_y1_d;
            n_cb_q      <= n_cb_d;
            n_y0_q      <= n_y0_d;
            n_cr_q      <= n_cr_d;
            sol_pend_q  <= sol_pend_d;
            out_valid_q <= out_valid_d;
            out_sol_q   <= out_sol_d;
            out_eol_q   <= out_eol_d;
            y_q         <= y_d;
            cb_q        <= cb_d;
            cr_q        <= cr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sol   = out_sol_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.y         = y_q;
    assign bus.cb        = cb_q;
    assign bus.cr        = cr_q;

endmodule

// File: tb/tb_ycrcb422_to_444.sv
// Self-checking bench for ycrcb422_to_444: table vectors, directed line sequences
// and randomized lines compared against a pixel-level reference model.
module tb_ycrcb422_to_444;

    localparam int unsigned DW = 10;

    typedef struct {
        logic [DW-1:0] cb, y0, cr, y1;
    } pair_t;

    typedef struct {
        logic [DW-1:0] y, cb, cr;
        logic          sol, eol;
    } pix_t;

    typedef struct {
        int cb0, cb1, cr0, cr1, exp_cb, exp_cr;
    } tv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ycrcb422_to_444_if #(.DW(DW)) bus ();

    ycrcb422_to_444 #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    rdy_low = 0;
    pair_t line[$];
    pix_t  exp_q[$];
    pix_t  got_q[$];
    tv_t   tv[6];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1)
            got_q.push_back('{y: bus.y, cb: bus.cb, cr: bus.cr, sol: bus.out_sol, eol: bus.out_eol});
        if (rst_n && bus.in_ready !== 1'b1) rdy_low++;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
        bus.in_eol   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic sol, input logic eol,
                             input int gap);
        logic rdy;
        int   n;
        idle(gap);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_sol   = sol;
        bus.in_eol   = eol;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 16) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
        bus.in_eol   = 1'b0;
    endtask

    // Sends the pairs in 'line'; noise raises in_eol on non-final words, which must be ignored.
    task automatic send_line(input bit with_eol, input int gap_max, input bit noise);
        logic [DW-1:0] d;
        logic          sol, eol;
        for (int p = 0; p < line.size(); p++) begin
            for (int w = 0; w < 4; w++) begin
                case (w)
                    0:       d = line[p].cb;
                    1:       d = line[p].y0;
                    2:       d = line[p].cr;
                    default: d = line[p].y1;
                endcase
                sol = (p == 0) && (w == 0);
                eol = with_eol && (p == line.size() - 1) && (w == 3);
                if (noise && w != 3 && $urandom_range(0, 3) == 0) eol = 1'b1;
                send_word(d, sol, eol, int'($urandom_range(0, gap_max)));
            end
        end
    endtask

    // Pixel 2p takes pair p's chroma; pixel 2p+1 averages pairs p and p+1, or replicates
    // on the last pair. An abandoned line loses its last held pair.
    function automatic void model(input bit complete);
        int   n, npix, p;
        pix_t px;
        n    = line.size();
        npix = complete ? 2 * n : 2 * (n - 1);
        for (int j = 0; j < npix; j++) begin
            p     = j / 2;
            px.y  = (j % 2 == 1) ? line[p].y1 : line[p].y0;
            if (j % 2 == 0 || p == n - 1) begin
                px.cb = line[p].cb;
                px.cr = line[p].cr;
            end else begin
                px.cb = DW'((int'(line[p].cb) + int'(line[p + 1].cb) + 1) / 2);
                px.cr = DW'((int'(line[p].cr) + int'(line[p + 1].cr) + 1) / 2);
            end
            px.sol = (j == 0);
            px.eol = complete && (j == npix - 1);
            exp_q.push_back(px);
        end
    endfunction

    task automatic check_out(input string name);
        int n;
        idle(4);
        chk($sformatf("%s_count", name), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_px%0d_y", name, i), int'(got_q[i].y), int'(exp_q[i].y));
            chk($sformatf("%s_px%0d_cb", name, i), int'(got_q[i].cb), int'(exp_q[i].cb));
            chk($sformatf("%s_px%0d_cr", name, i), int'(got_q[i].cr), int'(exp_q[i].cr));
            chk($sformatf("%s_px%0d_sol", name, i), int'(got_q[i].sol), int'(exp_q[i].sol));
            chk($sformatf("%s_px%0d_eol", name, i), int'(got_q[i].eol), int'(exp_q[i].eol));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic void rand_line(input int n);
        line.delete();
        for (int p = 0; p < n; p++)
            line.push_back('{cb: DW'($urandom_range(0, 1023)), y0: DW'($urandom_range(0, 1023)),
                             cr: DW'($urandom_range(0, 1023)), y1: DW'($urandom_range(0, 1023))});
    endfunction

    initial begin
        int exp_cb[6];
        int exp_cr[6];
        int n;
        bit abandon;

        tv[0] = '{cb0: 100, cb1: 200, cr0: 400, cr1: 500, exp_cb: 150, exp_cr: 450};
        tv[1] = '{cb0: 1023, cb1: 1022, cr0: 0, cr1: 1, exp_cb: 1023, exp_cr: 1};
        tv[2] = '{cb0: 0, cb1: 1, cr0: 1023, cr1: 1022, exp_cb: 1, exp_cr: 1023};
        tv[3] = '{cb0: 1023, cb1: 0, cr0: 0, cr1: 1023, exp_cb: 512, exp_cr: 512};
        tv[4] = '{cb0: 5, cb1: 6, cr0: 3, cr1: 4, exp_cb: 6, exp_cr: 4};
        tv[5] = '{cb0: 10, cb1: 10, cr0: 7, cr1: 9, exp_cb: 10, exp_cr: 8};
        exp_cb = '{100, 150, 200, 250, 300, 300};
        exp_cr = '{400, 450, 500, 550, 600, 600};

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
        bus.in_eol   = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_cb", int'(bus.cb), 0);
        chk("rst_cr", int'(bus.cr), 0);
        chk("rst_sol_eol", int'({bus.out_sol, bus.out_eol}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Three-pair reference line, back to back, against literal expected values.
        line.delete();
        line.push_back('{cb: 100, y0: 1, cr: 400, y1: 2});
        line.push_back('{cb: 200, y0: 3, cr: 500, y1: 4});
        line.push_back('{cb: 300, y0: 5, cr: 600, y1: 6});
        send_line(1'b1, 0, 1'b0);
        idle(4);
        chk("ref_count", got_q.size(), 6);
        if (got_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("ref_px%0d_y", i), int'(got_q[i].y), i + 1);
                chk($sformatf("ref_px%0d_cb", i), int'(got_q[i].cb), exp_cb[i]);
                chk($sformatf("ref_px%0d_cr", i), int'(got_q[i].cr), exp_cr[i]);
                chk($sformatf("ref_px%0d_sol", i), int'(got_q[i].sol), (i == 0) ? 1 : 0);
                chk($sformatf("ref_px%0d_eol", i), int'(got_q[i].eol), (i == 5) ? 1 : 0);
            end
        end
        got_q.delete();

        // Same line with random idle gaps.
        send_line(1'b1, 3, 1'b0);
        model(1'b1);
        check_out("gapped");

        // Interpolation / rounding table, two-pair lines.
        for (int t = 0; t < 6; t++) begin
            line.delete();
            line.push_back('{cb: DW'(tv[t].cb0), y0: 10'd11, cr: DW'(tv[t].cr0), y1: 10'd12});
            line.push_back('{cb: DW'(tv[t].cb1), y0: 10'd13, cr: DW'(tv[t].cr1), y1: 10'd14});
            send_line(1'b1, 1, 1'b0);
            idle(4);
            chk($sformatf("tv%0d_count", t), got_q.size(), 4);
            if (got_q.size() == 4) begin
                chk($sformatf("tv%0d_cb_interp", t), int'(got_q[1].cb), tv[t].exp_cb);
                chk($sformatf("tv%0d_cr_interp", t), int'(got_q[1].cr), tv[t].exp_cr);
                chk($sformatf("tv%0d_cb_repl", t), int'(got_q[3].cb), tv[t].cb1);
                chk($sformatf("tv%0d_cr_repl", t), int'(got_q[3].cr), tv[t].cr1);
            end
            got_q.delete();
        end

        // Single-pair line: both pixels from the flush states, ready low for two cycles.
        line.delete();
        line.push_back('{cb: 7, y0: 8, cr: 9, y1: 10});
        rdy_low = 0;
        send_line(1'b1, 0, 1'b0);
        model(1'b1);
        check_out("single");
        chk("single_ready_low_cycles", rdy_low, 2);

        // Start-of-line after two pairs abandons the first line.
        rand_line(2);
        send_line(1'b0, 0, 1'b0);
        model(1'b0);
        rand_line(3);
        send_line(1'b1, 0, 1'b0);
        model(1'b1);
        check_out("midsol");

        // Reset while in FLUSH0: only the pixels emitted before it appear.
        rand_line(2);
        send_line(1'b1, 0, 1'b0);
        rst_n = 1'b0;
        model(1'b0);
        idle(2);
        @(negedge clk);
        chk("flush_rst_in_ready", int'(bus.in_ready), 0);
        chk("flush_rst_out_valid", int'(bus.out_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_out("flush_rst");
        rand_line(2);
        send_line(1'b1, 1, 1'b0);
        model(1'b1);
        check_out("after_rst");

        // Random lines with gaps, ignored eol noise, junk words and occasional abandonment.
        for (int t = 0; t < 12; t++) begin
            n       = int'($urandom_range(1, 5));
            abandon = ($urandom_range(0, 3) == 0);
            rand_line(n);
            send_line(!abandon, 3, 1'b1);
            model(!abandon);
            if (abandon) begin
                rand_line(int'($urandom_range(1, 4)));
                send_line(1'b1, 2, 1'b1);
                model(1'b1);
            end
            send_word(DW'($urandom_range(0, 1023)), 1'b0, 1'b0, int'($urandom_range(0, 2)));
            check_out($sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ycrcb422_to_444.md
YCRCB422_TO_444 -- requirements
Module: ycrcb422_to_444

Interface
REQ-001 Parameter DW, default 10, sample width of every luma/chroma word.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_data  input  DW  multiplexed 4:2:2 word stream, order Cb,Y,Cr,Y per pixel pair.
REQ-005 in_valid  input  1  in_data valid; a word is accepted when in_valid && in_ready.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_sol  input  1  start of line; qualifies the accepted word as Cb of pair 0.
REQ-008 in_eol  input  1  end of line; qualifies the accepted word as final Y of the last pair.
REQ-009 out_valid  output  1  one-cycle strobe, y/cr/cb hold a 4:4:4 pixel; no backpressure.
REQ-010 y, cr, cb  output  DW each  registered 4:4:4 pixel, direct feed to the colour-space converter.
REQ-011 out_sol, out_eol  output  1 each  asserted with out_valid on the first/last pixel of a line.

Function
REQ-012 The block SHALL keep a 2-bit phase counter (0=Cb,1=Y0,2=Cr,3=Y1) that advances only on accepted words and wraps 3->0.
REQ-013 The FSM SHALL have states IDLE, FILL, RUN, FLUSH0, FLUSH1.
REQ-014 IDLE: accepted words without in_sol SHALL be discarded; accepted word with in_sol SHALL load Cb, set phase 1, go FILL.
REQ-015 FILL: the first pair SHALL be captured into the hold registers with no output; accepting phase 3 SHALL go RUN, or FLUSH0 if in_eol.
REQ-016 RUN: pair k is held while pair k+1 is received; acceptance of phase 2 of pair k+1 SHALL present pixel 2k next cycle (y=Y2k, cb=Cb2k, cr=Cr2k).
REQ-017 RUN: acceptance of phase 3 of pair k+1 SHALL present pixel 2k+1 next cycle, cb=(Cb2k+Cb2k+2+1)>>1, cr=(Cr2k+Cr2k+2+1)>>1, computed at DW+1 bits, no overflow; pair k+1 then becomes the held pair.
REQ-018 Acceptance of phase 3 with in_eol in RUN SHALL emit pixel 2k+1 as REQ-017 and go FLUSH0.
REQ-019 FLUSH0 SHALL emit pixel 2L of the held last pair; FLUSH1 SHALL emit pixel 2L+1 with chroma replicated (cb=Cb2L, cr=Cr2L), out_eol=1, then go IDLE.
REQ-020 in_ready SHALL be 0 in FLUSH0 and FLUSH1 and 1 in all other states.
REQ-021 out_sol SHALL accompany the first emitted pixel of each line only.
REQ-022 in_sol accepted in FILL or RUN SHALL abandon the current line (held pair discarded, no flush output) and restart as in IDLE with that word as Cb.
REQ-023 in_eol on a phase other than 3 SHALL be ignored; in_sol on an accepted word SHALL take priority over in_eol.
REQ-024 Idle cycles (in_valid=0) SHALL NOT advance phase or produce output; out_valid SHALL be 0 except as specified.
REQ-025 Maximum throughput: one word per cycle in, one pixel per two words out.

Reset
REQ-026 rst_n=0 SHALL force state IDLE, phase 0, hold registers 0, out_valid/out_sol/out_eol 0, y/cr/cb 0, in_ready 0 during reset and 1 the cycle after.
REQ-027 Reset mid-line or mid-flush SHALL discard all buffered data with no further output.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, phase constants PH_CB, PH_Y0, PH_CR, PH_Y1, and default DW.
REQ-029 Chroma averaging SHALL be one sub-module chroma_avg (two DW inputs, rounded mean, combinational), instantiated twice.

Verification
REQ-030 Line of 3 pairs Cb=100/200/300, Cr=400/500/600, Y=1..6 back-to-back -> 6 pixels, cb=100,150,200,250,300,300, cr=400,450,500,550,600,600, out_sol on pixel 0, out_eol on pixel 5.
REQ-031 Rounding: Cb2k=1023, Cb2k+2=1022 -> interpolated cb=1023; 0 and 1 -> 1.
REQ-032 Single-pair line (in_sol and in_eol in one pair) -> two pixels in FLUSH0/FLUSH1, chroma equal, in_ready low for exactly those 2 cycles.
REQ-033 Random in_valid gaps on REQ-030 stimulus -> identical pixel values and order.
REQ-034 in_sol mid-line after 2 pairs -> first line yields 2 pixels, no out_eol; new line decoded correctly.
REQ-035 rst_n low during FLUSH0 -> no further out_valid; next line with in_sol decodes normally.
